// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result-path selectors.
// Mode encodings and the parametrised-mux range check live here.
package alu_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   function automatic logic sel_out_of_range(input int sel, input int n);
      return sel >= n;
   endfunction

endpackage

// File: rtl/chan_select_rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first request
// found after ptr, wrapping mod N.
module rr_arbiter #(
   parameter int N  = 6,
   localparam int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;
   logic           w_found;
   int             w_idx;

   // Rotate so ptr+1 lands at bit 0, pick lowest, rotate the index back.
   always_comb begin
      w_dbl   = {req, req} >> (int'(ptr) + 1);
      w_rot   = w_dbl[N-1:0];
      gnt     = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < N; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_idx   = int'(ptr) + 1 + k;
            if (w_idx >= N) w_idx = w_idx - N;
            gnt     = {{(N-1){1'b0}}, 1'b1} << w_idx;
         end
      end
   end

endmodule

// File: rtl/chan_select_rr.sv
// Registered N-channel selector: direct index or round-robin grant
// feeding a single valid/ready output stage.
module chan_select_rr
   import alu_pkg::*;
#(
   parameter int N  = 6,
   parameter int W  = 16,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]  in_valid,
   output logic [N-1:0]  in_ready,
   input  logic          mode,
   input  logic [SW-1:0] sel,
   output logic [W-1:0]  out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [SW-1:0] out_chan,
   output logic          sel_err
);

   logic [W-1:0]  r_out_data;
   logic          r_out_valid;
   logic [SW-1:0] r_out_chan;
   logic          r_sel_err;
   logic [SW-1:0] r_ptr;

   logic          w_load_en;
   logic          w_sel_oob;
   logic [N-1:0]  w_rr_gnt;
   logic [N-1:0]  w_dir_gnt;
   logic [N-1:0]  w_gnt;
   logic [N-1:0]  w_acc;
   logic          w_xfer;
   logic [SW-1:0] w_idx;
   logic [W-1:0]  w_data;

   rr_arbiter #(.N(N)) u_arb (
      .req (in_valid),
      .ptr (r_ptr),
      .gnt (w_rr_gnt)
   );

   assign w_load_en = !r_out_valid || out_ready;
   assign w_sel_oob = sel_out_of_range(int'(sel), N);

   always_comb begin
      w_dir_gnt = '0;
      if (!w_sel_oob && in_valid[sel]) w_dir_gnt[sel] = 1'b1;
   end

   assign w_gnt    = (mode == MODE_RR) ? w_rr_gnt : w_dir_gnt;
   assign in_ready = w_gnt & {N{w_load_en}} & {N{rst_n}};
   assign w_acc    = in_ready & in_valid;
   assign w_xfer   = |w_acc;

   always_comb begin
      w_idx  = '0;
      w_data = '0;
      for (int i = 0; i < N; i++) begin
         if (w_acc[i]) begin
            w_idx  = SW'(i);
            w_data = in_data[i*W +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_chan  <= '0;
         r_sel_err   <= 1'b0;
         r_ptr       <= SW'(N - 1);
      end else begin
         r_sel_err <= (mode == MODE_DIRECT) && w_sel_oob;
         if (w_xfer) begin
            r_out_data  <= w_data;
            r_out_chan  <= w_idx;
            r_out_valid <= 1'b1;
            if (mode == MODE_RR) r_ptr <= w_idx;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_chan  = r_out_chan;
   assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_chan_select_rr.sv
// Directed bench for chan_select_rr (N=6, W=16).
module tb_chan_select_rr;

   localparam int N  = 6;
   localparam int W  = 16;
   localparam int SW = $clog2(N);

   logic          clk;
   logic          rst_n;
   logic [N*W-1:0] in_data;
   logic [N-1:0]  in_valid;
   logic [N-1:0]  in_ready;
   logic          mode;
   logic [SW-1:0] sel;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_chan;
   logic          sel_err;

   int errors = 0;
   int checks = 0;

   chan_select_rr #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan),
      .sel_err   (sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int i, input logic [W-1:0] v);
      in_data[i*W +: W] = v;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mode = 1'b0; sel = '0;
      in_valid = '1; out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (out_data !== 16'h0000) begin
         errors++; $display("FAIL rst_data got=%h exp=0000", out_data);
      end
      checks++;
      if (out_chan !== 3'd0) begin
         errors++; $display("FAIL rst_chan got=%0d exp=0", out_chan);
      end
      checks++;
      if (sel_err !== 1'b0) begin
         errors++; $display("FAIL rst_selerr got=%b exp=0", sel_err);
      end
      checks++;
      if (in_ready !== 6'b000000) begin
         errors++; $display("FAIL rst_inready got=%b exp=000000", in_ready);
      end
      in_valid = '0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_direct_basic();
      mode = 1'b0; sel = 3'd3; out_ready = 1'b1;
      set_ch(3, 16'hBEEF);
      in_valid = 6'b001000;
      #1;
      checks++;
      if (in_ready !== 6'b001000) begin
         errors++; $display("FAIL dir_inready got=%b exp=001000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_chan !== 3'd3) begin
         errors++;
         $display("FAIL dir_out got=%b/%h/%0d exp=1/beef/3",
                  out_valid, out_data, out_chan);
      end
      in_valid = '0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'hBEEF) begin
         errors++;
         $display("FAIL dir_drain got=%b/%h exp=0/beef", out_valid, out_data);
      end
   endtask

   task automatic test_out_of_range();
      for (int i = 0; i < N; i++) set_ch(i, 16'(i << 8));
      mode = 1'b0; sel = 3'd7; in_valid = '1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 6'b000000) begin
         errors++; $display("FAIL oor_inready got=%b exp=000000", in_ready);
      end
      tick();
      checks++;
      if (sel_err !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'hBEEF) begin
         errors++;
         $display("FAIL oor_first got=%b/%b/%h exp=1/0/beef",
                  sel_err, out_valid, out_data);
      end
      tick();
      checks++;
      if (sel_err !== 1'b1) begin
         errors++; $display("FAIL oor_second got=%b exp=1", sel_err);
      end
      sel = 3'd0; in_valid = '0;
      tick();
      checks++;
      if (sel_err !== 1'b0) begin
         errors++; $display("FAIL oor_clear got=%b exp=0", sel_err);
      end
   endtask

   task automatic test_rr_fairness();
      logic [SW-1:0] exp_seq [6];
      exp_seq = '{3'd0, 3'd2, 3'd5, 3'd0, 3'd2, 3'd5};
      mode = 1'b1; sel = 3'd7; in_valid = 6'b100101; out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_chan !== exp_seq[k] ||
             out_data !== 16'({exp_seq[k], 8'h00})) begin
            errors++;
            $display("FAIL rr_seq%0d got=%b/%0d/%h exp=1/%0d/%h", k,
                     out_valid, out_chan, out_data, exp_seq[k],
                     16'({exp_seq[k], 8'h00}));
         end
         checks++;
         if (sel_err !== 1'b0) begin
            errors++; $display("FAIL rr_selerr%0d got=%b exp=0", k, sel_err);
         end
      end
   endtask

   task automatic test_reset_midstream();
      tick();
      tick();
      checks++;
      if (out_chan !== 3'd2) begin
         errors++; $display("FAIL mid_pre got=%0d exp=2", out_chan);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000 || sel_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst got=%b/%h/%b exp=0/0000/0",
                  out_valid, out_data, sel_err);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_chan !== 3'd0) begin
         errors++;
         $display("FAIL mid_first got=%b/%0d exp=1/0", out_valid, out_chan);
      end
   endtask

   task automatic test_mode_switch();
      mode = 1'b1; in_valid = 6'b100101;
      tick();
      checks++;
      if (out_chan !== 3'd2) begin
         errors++; $display("FAIL sw_rr got=%0d exp=2", out_chan);
      end
      mode = 1'b0; sel = 3'd4; in_valid = '1;
      #1;
      checks++;
      if (in_ready !== 6'b010000) begin
         errors++; $display("FAIL sw_dir_rdy got=%b exp=010000", in_ready);
      end
      tick();
      checks++;
      if (out_chan !== 3'd4 || out_data !== 16'h0400) begin
         errors++;
         $display("FAIL sw_dir got=%0d/%h exp=4/0400", out_chan, out_data);
      end
      mode = 1'b1;
      tick();
      checks++;
      if (out_chan !== 3'd3 || out_data !== 16'h0300) begin
         errors++;
         $display("FAIL sw_back got=%0d/%h exp=3/0300", out_chan, out_data);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; mode = 1'b0; sel = 3'd1;
      in_valid = 6'b000010; set_ch(1, 16'h1111);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (in_ready !== 6'b000000) begin
            errors++; $display("FAIL bp_rdy%0d got=%b exp=000000", k, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 16'h0300 || out_chan !== 3'd3) begin
            errors++;
            $display("FAIL bp_hold%0d got=%b/%h/%0d exp=1/0300/3", k,
                     out_valid, out_data, out_chan);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 6'b000010) begin
         errors++; $display("FAIL bp_rel_rdy got=%b exp=000010", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h1111 || out_chan !== 3'd1) begin
         errors++;
         $display("FAIL bp_rel got=%b/%h/%0d exp=1/1111/1",
                  out_valid, out_data, out_chan);
      end
   endtask

   initial begin
      in_data = '0;
      test_reset();
      test_direct_basic();
      test_out_of_range();
      test_rr_fairness();
      test_reset_midstream();
      test_mode_switch();
      test_backpressure();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
